// File: rtl/wb_regfile.sv
// Write-back stage and 32-entry register file for the MIPS pipeline.
// Two combinational read ports with same-cycle write bypass; $zero is hardwired.
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Read_New_1,
  input  logic [DATA_W-1:0] Data_New_1,
  input  logic [AW-1:0]     Write_Reg_Final,
  input  logic              Reg_Wr3,
  input  logic              Mem_To_Reg3,
  input  logic [AW-1:0]     Read_Reg1,
  input  logic [AW-1:0]     Read_Reg2,
  output logic [DATA_W-1:0] Read_Data1,
  output logic [DATA_W-1:0] Read_Data2,
  output logic [DATA_W-1:0] WB_Data,
  output logic [31:0]       wb_count
);

  logic [DATA_W-1:0] regs_reg [NREGS];
  logic [31:0]       count_reg;
  logic              we_eff;

  assign WB_Data  = Mem_To_Reg3 ? Read_New_1 : Data_New_1;
  assign we_eff   = Reg_Wr3 && (Write_Reg_Final != '0);
  assign wb_count = count_reg;

  // Entry 0 is only ever cleared; the read ports mask it anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_reg[i] <= '0;
      end
      count_reg <= '0;
    end else if (we_eff) begin
      regs_reg[Write_Reg_Final] <= WB_Data;
      count_reg                 <= count_reg + 32'd1;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [AW-1:0]     addr;
      logic [DATA_W-1:0] data;

      assign addr = (gi == 0) ? Read_Reg1 : Read_Reg2;

      // Bypass the in-flight write so ID sees it in the same cycle.
      always_comb begin
        if (addr == '0) begin
          data = '0;
        end else if (we_eff && (addr == Write_Reg_Final)) begin
          data = WB_Data;
        end else begin
          data = regs_reg[addr];
        end
      end
    end
  endgenerate

  assign Read_Data1 = g_rd[0].data;
  assign Read_Data2 = g_rd[1].data;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: vector table for per-cycle behaviour,
// scoreboard queue for post-edge counter values, plus a counter wrap sequence.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Read_New_1;
  logic [31:0] Data_New_1;
  logic [4:0]  Write_Reg_Final;
  logic        Reg_Wr3;
  logic        Mem_To_Reg3;
  logic [4:0]  Read_Reg1;
  logic [4:0]  Read_Reg2;
  logic [31:0] Read_Data1;
  logic [31:0] Read_Data2;
  logic [31:0] WB_Data;
  logic [31:0] wb_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk            (clk),
    .rst            (rst),
    .Read_New_1     (Read_New_1),
    .Data_New_1     (Data_New_1),
    .Write_Reg_Final(Write_Reg_Final),
    .Reg_Wr3        (Reg_Wr3),
    .Mem_To_Reg3    (Mem_To_Reg3),
    .Read_Reg1      (Read_Reg1),
    .Read_Reg2      (Read_Reg2),
    .Read_Data1     (Read_Data1),
    .Read_Data2     (Read_Data2),
    .WB_Data        (WB_Data),
    .wb_count       (wb_count)
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        we;
    logic        m2r;
    logic [4:0]  wreg;
    logic [31:0] rn;
    logic [31:0] dn;
    logic [4:0]  rr1;
    logic [4:0]  rr2;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_wbd;
    logic [31:0] exp_cnt;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] cnt;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst             = v.rst;
    Reg_Wr3         = v.we;
    Mem_To_Reg3     = v.m2r;
    Write_Reg_Final = v.wreg;
    Read_New_1      = v.rn;
    Data_New_1      = v.dn;
    Read_Reg1       = v.rr1;
    Read_Reg2       = v.rr2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    sb_t s;
    rst = 1'b1; Reg_Wr3 = 1'b0; Mem_To_Reg3 = 1'b0; Write_Reg_Final = '0;
    Read_New_1 = '0; Data_New_1 = '0; Read_Reg1 = '0; Read_Reg2 = '0;

    //              name          rst we m2r wreg rn            dn            rr1 rr2  rd1           rd2           wbd           cnt
    vecs.push_back('{"rst_wr_a",   1, 1, 0,  5, 32'h0,        32'hDEADBEEF, 5,  0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0});
    vecs.push_back('{"rst_wr_b",   1, 1, 0,  5, 32'h0,        32'hDEADBEEF, 5,  0,  32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0});
    vecs.push_back('{"post_rst",   0, 0, 0,  5, 32'h0,        32'hDEADBEEF, 5,  5,  32'h0,        32'h0,        32'hDEADBEEF, 0});
    vecs.push_back('{"wr_r8_ld",   0, 1, 1,  8, 32'h12345678, 32'hAAAAAAAA, 8,  0,  32'h12345678, 32'h0,        32'h12345678, 1});
    vecs.push_back('{"rd_r8",      0, 0, 1,  8, 32'h12345678, 32'hAAAAAAAA, 0,  8,  32'h0,        32'h12345678, 32'h12345678, 1});
    vecs.push_back('{"byp_r9",     0, 1, 0,  9, 32'h0,        32'h55,       9,  9,  32'h55,       32'h55,       32'h55,       2});
    vecs.push_back('{"rd_r9_r8",   0, 0, 0,  9, 32'h0,        32'h0,        9,  8,  32'h55,       32'h12345678, 32'h0,        2});
    vecs.push_back('{"wr_r0",      0, 1, 0,  0, 32'h0,        32'hFFFFFFFF, 0,  0,  32'h0,        32'h0,        32'hFFFFFFFF, 2});
    vecs.push_back('{"after_r0",   0, 0, 0,  0, 32'h0,        32'hFFFFFFFF, 0,  9,  32'h0,        32'h55,       32'hFFFFFFFF, 2});
    vecs.push_back('{"rst_vs_wr",  1, 1, 0,  3, 32'h0,        32'h77,       3,  8,  32'h77,       32'h12345678, 32'h77,       0});
    vecs.push_back('{"rd_r3_r8",   0, 0, 0,  3, 32'h0,        32'h0,        3,  8,  32'h0,        32'h0,        32'h0,        0});
    vecs.push_back('{"wr_r4_1",    0, 1, 0,  4, 32'h0,        32'h1,        4,  0,  32'h1,        32'h0,        32'h1,        1});
    vecs.push_back('{"wr_r4_2",    0, 1, 0,  4, 32'h0,        32'h2,        4,  4,  32'h2,        32'h2,        32'h2,        2});
    vecs.push_back('{"wr_r4_3",    0, 1, 0,  4, 32'h0,        32'h3,        4,  4,  32'h3,        32'h3,        32'h3,        3});
    vecs.push_back('{"idle_a",     0, 0, 0,  4, 32'h0,        32'h9,        4,  3,  32'h3,        32'h0,        32'h9,        3});
    vecs.push_back('{"idle_b",     0, 0, 0,  4, 32'h0,        32'h9,        4,  3,  32'h3,        32'h0,        32'h9,        3});
    vecs.push_back('{"mux_no_wr",  0, 0, 1, 31, 32'hCAFEF00D, 32'h0,        31, 4,  32'h0,        32'h3,        32'hCAFEF00D, 3});
    vecs.push_back('{"wr_r31",     0, 1, 1, 31, 32'hCAFEF00D, 32'h0,        30, 31, 32'h0,        32'hCAFEF00D, 32'hCAFEF00D, 4});
    vecs.push_back('{"rd_r31",     0, 0, 0, 31, 32'h2,        32'h1,        31, 0,  32'hCAFEF00D, 32'h0,        32'h1,        4});

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      $display("vec %0d %s: rd1=%h rd2=%h wbd=%h", i, vecs[i].name, Read_Data1, Read_Data2, WB_Data);
      chk({vecs[i].name, ".rd1"}, Read_Data1, vecs[i].exp_rd1);
      chk({vecs[i].name, ".rd2"}, Read_Data2, vecs[i].exp_rd2);
      chk({vecs[i].name, ".wbd"}, WB_Data, vecs[i].exp_wbd);
      sb.push_back('{vecs[i].name, vecs[i].exp_cnt});
      @(posedge clk);
      #1;
      s = sb.pop_front();
      chk({s.name, ".cnt"}, wb_count, s.cnt);
    end

    // Counter wrap: preload all-ones, then one committed write.
    @(negedge clk);
    force dut.count_reg = 32'hFFFFFFFF;
    #1;
    release dut.count_reg;
    #1;
    $display("wrap preload: wb_count=%h", wb_count);
    chk("wrap.preload", wb_count, 32'hFFFFFFFF);
    drive('{"wrap_wr", 0, 1, 0, 6, 32'h0, 32'h66, 0, 0, 0, 0, 0, 0});
    sb.push_back('{"wrap", 32'h0});
    @(posedge clk);
    #1;
    s = sb.pop_front();
    $display("wrap write: wb_count=%h", wb_count);
    chk({s.name, ".cnt"}, wb_count, s.cnt);
    @(negedge clk);
    drive('{"wrap_rd", 0, 0, 0, 6, 32'h0, 32'h0, 6, 4, 0, 0, 0, 0});
    #1;
    $display("wrap read: rd1=%h rd2=%h", Read_Data1, Read_Data2);
    chk("wrap.r6", Read_Data1, 32'h66);
    chk("wrap.r4", Read_Data2, 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage and general-purpose register file for the 5-stage MIPS pipeline. It consumes the MEM/WB pipeline register outputs, selects the write-back value (load data or ALU result), and commits it to a 32 x 32-bit register file with $zero hardwired. It serves the ID stage's two combinational read ports with same-cycle write-to-read bypass, and keeps a retired-write counter for debug and verification.

## Interface
- DATA_W, 32, register and data width
- NREGS, 32, number of architectural registers; address width is log2(NREGS) = 5
- clk  in  1  pipeline clock; all state updates on the rising edge
- rst  in  1  synchronous, active-high reset
- Read_New_1  in  32  load data from the MEM/WB register
- Data_New_1  in  32  ALU result from the MEM/WB register
- Write_Reg_Final  in  5  destination register from the MEM/WB register
- Reg_Wr3  in  1  register-write enable from the MEM/WB register
- Mem_To_Reg3  in  1  1 selects Read_New_1, 0 selects Data_New_1
- Read_Reg1  in  5  ID-stage rs address
- Read_Reg2  in  5  ID-stage rt address
- Read_Data1  out  32  rs value, combinational
- Read_Data2  out  32  rt value, combinational
- WB_Data  out  32  selected write-back value, combinational (feeds the forwarding mux)
- wb_count  out  32  count of committed register writes

## Operation
- WB_Data = Mem_To_Reg3 ? Read_New_1 : Data_New_1. This is purely combinational and is driven even when Reg_Wr3 = 0.
- Effective write: we_eff = Reg_Wr3 && (Write_Reg_Final != 0).
- On a rising edge with rst = 0 and we_eff = 1: regs[Write_Reg_Final] <= WB_Data.
- Register 0 is never written and always reads 0.
- Read port n (Read_Regn, Read_Datan):
  - address == 0 -> 0
  - else if we_eff and address == Write_Reg_Final -> WB_Data (bypass)
  - else -> regs[address]
- Both read ports are independent. Both may hit the bypass in the same cycle.
- wb_count increments by 1 on every edge where we_eff = 1. It wraps from 0xFFFFFFFF to 0. Writes to $0 and cycles with Reg_Wr3 = 0 do not count.
- Reset (rst = 1 at an edge):
  - all regs[1..31] <= 0
  - wb_count <= 0
  - reset overrides a coincident write; the write is lost and is not counted.
- During reset cycles, reads follow the same combinational rules. The bypass is still active because it is combinational, but the array and counter hold 0 after the edge.
- No X propagation: all storage has a defined reset value.

## Timing
- Write latency is 1 edge into the array; visibility to readers is 0 cycles via the bypass. This resolves the WB-to-ID structural hazard without a half-cycle register file.
- Read_Data1, Read_Data2 and WB_Data are combinational from their inputs and the current state, with no pipeline register.
- wb_count changes on the same edge as the array update.
- Reset values after the first rst edge:
  - Read_Data1 = Read_Data2 = 0 when no bypass is active
  - wb_count = 0
  - WB_Data follows its inputs
- Back-to-back writes to the same register on consecutive edges: last write wins. A read in each cycle returns that cycle's bypass value.

## Test plan
- Reset: assert rst for 2 cycles with Reg_Wr3 = 1, Write_Reg_Final = 5 and Data_New_1 = 0xDEADBEEF. Then deassert and read r5 with Reg_Wr3 = 0. Required: Read_Data1 = 0 and wb_count = 0.
- Write/read with mux:
  - Write r8 with Mem_To_Reg3 = 1, Read_New_1 = 0x12345678, Data_New_1 = 0xAAAAAAAA.
  - Next cycle, read Read_Reg2 = 8 with Reg_Wr3 = 0. Required: Read_Data2 = 0x12345678 and wb_count = 1.
- Bypass: in one cycle set Reg_Wr3 = 1, Write_Reg_Final = 9, Mem_To_Reg3 = 0, Data_New_1 = 0x55 and Read_Reg1 = Read_Reg2 = 9. Required: Read_Data1 = Read_Data2 = 0x55 in that same cycle, before the edge.
- $zero:
  - Write r0 with 0xFFFFFFFF. Required: Read_Data1 = 0 for Read_Reg1 = 0, both during the write cycle and after it, and wb_count unchanged.
- Reset vs write: assert rst with a valid write to r3 = 0x77 in the same cycle. Required: r3 reads 0 afterwards and wb_count = 0.
- Counter and last-write-wins:
  - Perform 3 consecutive writes to r4 with values 1, 2, 3, then 2 cycles with Reg_Wr3 = 0.
  - Required: r4 = 3, wb_count = 3, and no counting during the idle cycles.
  - Force wb_count to 0xFFFFFFFF in simulation and perform one write. Required: wb_count = 0.
